// File: rtl/count_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : count_uart_tx
// Brief    : Sends an 8-bit counter snapshot as a UART frame (8N1, LSB first).
//            Hand-off is a valid/ready handshake that accepts only in IDLE.
//            Define COUNT_UART_PARITY_EN to add an even-parity bit (8E1).
// Revision : 1.0 - initial release
// ============================================================================
module count_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_W - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_STOP   = 3'd3;
`ifdef COUNT_UART_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd4;
`endif

    logic [2:0]         r_state, w_state_next;
    logic [c_CNT_W-1:0] r_cnt,   w_cnt_next;
    logic [c_IDX_W-1:0] r_idx,   w_idx_next;
    logic [DATA_W-1:0]  r_shift, w_shift_next;
    logic               r_tx,    w_tx_next;
    logic               w_bit_done;
`ifdef COUNT_UART_PARITY_EN
    logic               r_parity, w_parity_next;
`endif

    assign w_bit_done = (r_cnt == c_CNT_LAST);

    // tx is the next-cycle line level, so every output bit comes straight from r_tx
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
`ifdef COUNT_UART_PARITY_EN
        w_parity_next = r_parity;
`endif
        case (r_state)
            c_ST_IDLE: begin
                w_tx_next  = 1'b1;
                w_cnt_next = '0;
                if (in_valid) begin
                    w_shift_next = in_data;
                    w_tx_next    = 1'b0;
                    w_state_next = c_ST_START;
`ifdef COUNT_UART_PARITY_EN
                    w_parity_next = ^in_data;
`endif
                end
            end
            c_ST_START: begin
                if (w_bit_done) begin
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_tx_next    = r_shift[0];
                    w_shift_next = r_shift >> 1;
                    w_state_next = c_ST_DATA;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end
            c_ST_DATA: begin
                if (w_bit_done) begin
                    w_cnt_next = '0;
                    if (r_idx == c_IDX_LAST) begin
`ifdef COUNT_UART_PARITY_EN
                        w_tx_next    = r_parity;
                        w_state_next = c_ST_PARITY;
`else
                        w_tx_next    = 1'b1;
                        w_state_next = c_ST_STOP;
`endif
                    end else begin
                        w_idx_next   = r_idx + c_IDX_W'(1);
                        w_tx_next    = r_shift[0];
                        w_shift_next = r_shift >> 1;
                    end
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end
`ifdef COUNT_UART_PARITY_EN
            c_ST_PARITY: begin
                if (w_bit_done) begin
                    w_cnt_next   = '0;
                    w_tx_next    = 1'b1;
                    w_state_next = c_ST_STOP;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end
`endif
            c_ST_STOP: begin
                if (w_bit_done) begin
                    w_cnt_next   = '0;
                    w_tx_next    = 1'b1;
                    w_state_next = c_ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_tx_next    = 1'b1;
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
`ifdef COUNT_UART_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
`ifdef COUNT_UART_PARITY_EN
            r_parity <= w_parity_next;
`endif
        end
    end

    assign tx       = r_tx;
    assign in_ready = (r_state == c_ST_IDLE);
    assign busy     = ~in_ready;

endmodule
`default_nettype wire

// File: tb/tb_count_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_uart_tx
// Brief    : Scoreboard bench for count_uart_tx (CLKS_PER_BIT=4); stimulus
//            queues expected frames, a line monitor checks every tx cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_uart_tx;

    localparam int CPB = 4;
`ifdef COUNT_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;

    typedef struct {
        logic [10:0] bits;
        bit          aborted;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    bit   mon_active = 1'b0;
    int   cyc        = 0;

    count_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Frame bits LSB first: start, data[0..7], then parity (when enabled), stop
    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic p);
`ifdef COUNT_UART_PARITY_EN
        return {1'b1, p, d, 1'b0};
`else
        return {p, 1'b1, d, 1'b0};
`endif
    endfunction

    task automatic push(input logic [7:0] d, input logic p, input bit ab);
        exp_t e;
        e.bits    = make_frame(d, p);
        e.aborted = ab;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        check("ready_wait_bounded", n < 200, 1);
    endtask

    task automatic send(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_q.size() == 0 && !mon_active && in_ready) && n < 1000) begin
            @(posedge clk);
            #2 n++;
        end
        check("idle_reached", n < 1000, 1);
    endtask

    // Line monitor: pops one expectation per start bit and checks every cycle of the frame
    initial begin : monitor
        logic       prev_tx;
        logic [7:0] rx;
        exp_t       e;
        bit         ok;
        bit         ab;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev_tx === 1'b1 && tx === 1'b0) begin
                mon_active = 1'b1;
                if (exp_q.size() == 0) begin
                    e.bits    = '1;
                    e.aborted = 1'b0;
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_frame: start bit seen with no frame queued (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                end
                ok = 1'b1;
                ab = 1'b0;
                rx = '0;
                for (int c = 0; c < NB * CPB; c++) begin
                    if (c > 0) @(negedge clk);
                    if (rst) begin
                        ab = 1'b1;
                        break;
                    end
                    if (tx !== e.bits[c / CPB] || in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
                    if ((c % CPB) == CPB / 2 && (c / CPB) >= 1 && (c / CPB) <= 8)
                        rx[(c / CPB) - 1] = tx;
                end
                if (ab) begin
                    check("frame_aborted_expected", e.aborted, 1);
                end else begin
                    check($sformatf("frame_%02h_cycle_exact", e.bits[8:1]), ok && !e.aborted, 1);
                    check("frame_decode", rx, e.bits[8:1]);
                    @(negedge clk);
                    check("idle_after_frame {tx,ready,busy}", {tx, in_ready, busy}, 3'b110);
                end
                mon_active = 1'b0;
            end
            prev_tx = tx;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t0;
        int t1;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1 check("reset {tx,ready,busy}", {tx, in_ready, busy}, 3'b110);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Single frame 0xA5: line 0,1,0,1,0,0,1,0,1,1
        push(8'hA5, 1'b0, 1'b0);
        send(8'hA5);
        wait_idle();

        // Back-to-back with in_valid held: exactly one idle cycle between frames
        push(8'h00, 1'b0, 1'b0);
        push(8'hFF, 1'b0, 1'b0);
        in_data  = 8'h00;
        in_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1 t0 = cyc;
        in_data = 8'hFF;
        wait_ready();
        @(posedge clk);
        #1 t1 = cyc;
        in_valid = 1'b0;
        check("b2b_accept_spacing", t1 - t0, NB * CPB + 1);
        wait_idle();

        // Request while busy is dropped, in-flight data unaffected
        push(8'h3C, 1'b0, 1'b0);
        send(8'h3C);
        repeat (10) @(posedge clk);
        #1 in_data = 8'hC3;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle();

        // Reset while idle with in_valid high: nothing accepted
        @(posedge clk);
        #2 rst = 1'b1;
        in_data  = 8'h5A;
        in_valid = 1'b1;
        #1 check("async_reset_idle {tx,ready,busy}", {tx, in_ready, busy}, 3'b110);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("held_reset {tx,ready,busy}", {tx, in_ready, busy}, 3'b110);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;

        // Reset during data bit 3 of 0x81 abandons the frame
        push(8'h81, 1'b0, 1'b1);
        send(8'h81);
        repeat (16) @(posedge clk);
        #2 check("bit3_of_81_low", tx, 1'b0);
        #1 rst = 1'b1;
        #1 check("async_reset_midframe {tx,ready,busy}", {tx, in_ready, busy}, 3'b110);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        push(8'h55, 1'b0, 1'b0);
        send(8'h55);
        wait_idle();

`ifdef COUNT_UART_PARITY_EN
        push(8'h07, 1'b1, 1'b0);
        send(8'h07);
        wait_idle();
        push(8'h03, 1'b0, 1'b0);
        send(8'h03);
        wait_idle();
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
